// File: rtl/loop_sdram_scheduler.sv
// Per-frame SDRAM sequencer for the four-channel looper: one record write and up
// to four playback reads per sample tick over an Avalon-MM master port.
module loop_sdram_scheduler #(
   parameter logic [22:0] MAX_LEN = 23'd480000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic        record_en,
   input  logic [1:0]  rec_channel,
   input  logic [3:0]  play_mask,
   input  logic [31:0] rec_data,
   output logic [24:0] address,
   output logic        read_n,
   output logic        write_n,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   input  logic        readdatavalid,
   input  logic        waitrequest,
   output logic [31:0] play_data0,
   output logic [31:0] play_data1,
   output logic [31:0] play_data2,
   output logic [31:0] play_data3,
   output logic [22:0] len0,
   output logic [22:0] len1,
   output logic [22:0] len2,
   output logic [22:0] len3,
   output logic        frame_done,
   output logic        rec_full,
   output logic        overrun
);

   typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        ch_q, ch_d;
   logic              rec_q, rec_d;
   logic [1:0]        rch_q, rch_d;
   logic [3:0]        mask_q, mask_d;
   logic              prev_rec_q, prev_rec_d;
   logic [1:0]        prev_ch_q, prev_ch_d;
   logic [3:0][22:0]  len_q, len_d;
   logic [3:0][22:0]  pos_q, pos_d;
   logic [3:0][31:0]  play_q, play_d;
   logic [24:0]       address_q, address_d;
   logic              read_n_q, read_n_d;
   logic              write_n_q, write_n_d;
   logic [31:0]       writedata_q, writedata_d;
   logic              frame_done_q, frame_done_d;
   logic              rec_full_q, rec_full_d;
   logic              overrun_q, overrun_d;

   logic [3:0]        elig_in, elig_cap, elig_sel;
   logic              sel;
   logic [2:0]        start, nxt;
   logic              take;
   logic [22:0]       cur_len;

   // Lowest eligible channel at or above start; 4 means none left.
   function automatic logic [2:0] first_elig(input logic [3:0] elig, input logic [2:0] st);
      logic [2:0] r;
      r = 3'd4;
      for (int i = 3; i >= 0; i--) begin
         if (elig[i] && (3'(i) >= st)) r = 3'(i);
      end
      return r;
   endfunction

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         elig_in[c]  = play_mask[c] && (len_q[c] != 23'd0) && !(record_en && (rec_channel == 2'(c)));
         elig_cap[c] = mask_q[c] && (len_q[c] != 23'd0) && !(rec_q && (rch_q == 2'(c)));
      end
   end

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      rec_d        = rec_q;
      rch_d        = rch_q;
      mask_d       = mask_q;
      prev_rec_d   = prev_rec_q;
      prev_ch_d    = prev_ch_q;
      len_d        = len_q;
      pos_d        = pos_q;
      play_d       = play_q;
      address_d    = address_q;
      writedata_d  = writedata_q;
      read_n_d     = 1'b1;
      write_n_d    = 1'b1;
      frame_done_d = 1'b0;
      rec_full_d   = rec_full_q;
      overrun_d    = overrun_q;
      sel          = 1'b0;
      start        = 3'd0;
      elig_sel     = elig_cap;
      take         = 1'b0;
      cur_len      = 23'd0;
      nxt          = 3'd4;

      case (state_q)
         IDLE: begin
            if (sample_tick) begin
               rec_d      = record_en;
               rch_d      = rec_channel;
               mask_d     = play_mask;
               prev_rec_d = record_en;
               prev_ch_d  = rec_channel;
               take       = record_en && (!prev_rec_q || (rec_channel != prev_ch_q));
               cur_len    = take ? 23'd0 : len_q[rec_channel];
               elig_sel   = elig_in;
               if (!record_en || take) rec_full_d = 1'b0;
               if (take) begin
                  len_d[rec_channel] = 23'd0;
                  pos_d[rec_channel] = 23'd0;
               end
               if (record_en) begin
                  play_d[rec_channel] = rec_data;
                  if (cur_len == MAX_LEN) begin
                     rec_full_d = 1'b1;
                     sel        = 1'b1;
                  end else begin
                     state_d     = WR;
                     write_n_d   = 1'b0;
                     address_d   = {rec_channel, cur_len};
                     writedata_d = rec_data;
                  end
               end else begin
                  sel = 1'b1;
               end
            end
         end
         WR: begin
            write_n_d = 1'b0;
            if (!waitrequest) begin
               write_n_d    = 1'b1;
               len_d[rch_q] = len_q[rch_q] + 23'd1;
               sel          = 1'b1;
            end
         end
         RD_REQ: begin
            read_n_d = 1'b0;
            if (!waitrequest) begin
               read_n_d = 1'b1;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (readdatavalid) begin
               play_d[ch_q] = readdata;
               pos_d[ch_q]  = ((pos_q[ch_q] + 23'd1) == len_q[ch_q]) ? 23'd0 : pos_q[ch_q] + 23'd1;
               sel          = 1'b1;
               start        = {1'b0, ch_q} + 3'd1;
            end
         end
         DONE: begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (sample_tick && (state_q != IDLE)) overrun_d = 1'b1;

      // Advance to the next playing channel; a stale pos past a shrunken len restarts at 0.
      if (sel) begin
         nxt = first_elig(elig_sel, start);
         if (nxt[2]) begin
            state_d = DONE;
         end else begin
            state_d  = RD_REQ;
            ch_d     = nxt[1:0];
            read_n_d = 1'b0;
            if (pos_q[nxt[1:0]] >= len_q[nxt[1:0]]) begin
               pos_d[nxt[1:0]] = 23'd0;
               address_d       = {nxt[1:0], 23'd0};
            end else begin
               address_d = {nxt[1:0], pos_q[nxt[1:0]]};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ch_q         <= 2'd0;
         rec_q        <= 1'b0;
         rch_q        <= 2'd0;
         mask_q       <= 4'd0;
         prev_rec_q   <= 1'b0;
         prev_ch_q    <= 2'd0;
         len_q        <= '0;
         pos_q        <= '0;
         play_q       <= '0;
         address_q    <= 25'd0;
         read_n_q     <= 1'b1;
         write_n_q    <= 1'b1;
         writedata_q  <= 32'd0;
         frame_done_q <= 1'b0;
         rec_full_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         rec_q        <= rec_d;
         rch_q        <= rch_d;
         mask_q       <= mask_d;
         prev_rec_q   <= prev_rec_d;
         prev_ch_q    <= prev_ch_d;
         len_q        <= len_d;
         pos_q        <= pos_d;
         play_q       <= play_d;
         address_q    <= address_d;
         read_n_q     <= read_n_d;
         write_n_q    <= write_n_d;
         writedata_q  <= writedata_d;
         frame_done_q <= frame_done_d;
         rec_full_q   <= rec_full_d;
         overrun_q    <= overrun_d;
      end
   end

   assign address    = address_q;
   assign read_n     = read_n_q;
   assign write_n    = write_n_q;
   assign writedata  = writedata_q;
   assign play_data0 = play_q[0];
   assign play_data1 = play_q[1];
   assign play_data2 = play_q[2];
   assign play_data3 = play_q[3];
   assign len0       = len_q[0];
   assign len1       = len_q[1];
   assign len2       = len_q[2];
   assign len3       = len_q[3];
   assign frame_done = frame_done_q;
   assign rec_full   = rec_full_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_loop_sdram_scheduler.sv
// Directed bench for loop_sdram_scheduler with a small Avalon slave model (read latency 1).
module tb_loop_sdram_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        record_en = 1'b0;
   logic [1:0]  rec_channel = 2'd0;
   logic [3:0]  play_mask = 4'd0;
   logic [31:0] rec_data = 32'd0;
   logic [24:0] address;
   logic        read_n, write_n;
   logic [31:0] writedata;
   logic [31:0] readdata = 32'd0;
   logic        readdatavalid = 1'b0;
   logic        waitrequest = 1'b0;
   logic [31:0] play_data0, play_data1, play_data2, play_data3;
   logic [22:0] len0, len1, len2, len3;
   logic        frame_done, rec_full, overrun;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] A = 32'hA0A0_0001;
   localparam logic [31:0] B = 32'hB0B0_0002;
   localparam logic [31:0] C = 32'hC0C0_0003;
   localparam logic [31:0] D = 32'hD0D0_0004;

   loop_sdram_scheduler #(.MAX_LEN(23'd4)) dut (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .record_en(record_en),
      .rec_channel(rec_channel), .play_mask(play_mask), .rec_data(rec_data),
      .address(address), .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
      .play_data0(play_data0), .play_data1(play_data1), .play_data2(play_data2),
      .play_data3(play_data3), .len0(len0), .len1(len1), .len2(len2), .len3(len3),
      .frame_done(frame_done), .rec_full(rec_full), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Slave model: responds on the falling edge so the DUT sees stable inputs at posedge.
   int          stall_cnt = 0;
   logic [31:0] mem [64];
   logic        rd_pend = 1'b0;
   logic [24:0] pend_addr = 25'd0;
   logic [24:0] wr_log [$];
   logic [24:0] rd_log [$];

   function automatic int midx(input logic [24:0] a);
      return int'({a[24:23], a[3:0]});
   endfunction

   initial for (int i = 0; i < 64; i++) mem[i] = 32'd0;

   always @(negedge clk) begin
      readdatavalid = rd_pend;
      readdata      = rd_pend ? mem[midx(pend_addr)] : 32'hDEAD_BEEF;
      rd_pend       = 1'b0;
      if ((read_n === 1'b0 || write_n === 1'b0) && stall_cnt > 0) begin
         waitrequest = 1'b1;
         stall_cnt--;
      end else begin
         waitrequest = 1'b0;
      end
      if (!waitrequest && write_n === 1'b0) begin
         mem[midx(address)] = writedata;
         wr_log.push_back(address);
      end
      if (!waitrequest && read_n === 1'b0) begin
         rd_pend   = 1'b1;
         pend_addr = address;
         rd_log.push_back(address);
      end
   end

   // Issue one tick and follow the frame; cyc = cycles from tick to frame_done (0 on timeout).
   task automatic do_frame(input logic re, input logic [1:0] ch, input logic [3:0] mask,
                           input logic [31:0] d, input int extra_at,
                           output int cyc, output int rdlow, output logic stable, output int ndone);
      logic [24:0] a0;
      logic        seen;
      int          first;
      a0 = '0; seen = 1'b0; first = 0;
      cyc = 0; rdlow = 0; stable = 1'b1; ndone = 0;
      record_en = re; rec_channel = ch; play_mask = mask; rec_data = d;
      sample_tick = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         sample_tick = (i == extra_at);
         if (read_n === 1'b0) begin
            if (!seen) a0 = address;
            else if (address !== a0) stable = 1'b0;
            seen = 1'b1;
            rdlow++;
         end
         if (frame_done === 1'b1) begin
            ndone++;
            if (first == 0) first = i;
         end
         if (first != 0 && i >= first + 3) break;
      end
      cyc = first;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (read_n !== 1'b1 || write_n !== 1'b1) begin errors++; $display("FAIL reset_cmd: read_n=%b write_n=%b want 1 1", read_n, write_n); end
      checks++; if (address !== 25'd0 || writedata !== 32'd0) begin errors++; $display("FAIL reset_bus: addr=%h wdata=%h want 0 0", address, writedata); end
      checks++; if ({play_data0, play_data1, play_data2, play_data3} !== 128'd0) begin errors++; $display("FAIL reset_play: got nonzero play_data"); end
      checks++; if ({len0, len1, len2, len3} !== 92'd0) begin errors++; $display("FAIL reset_len: got nonzero len"); end
      checks++; if ({frame_done, rec_full, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {frame_done, rec_full, overrun}); end
   endtask

   task automatic test_idle_tick();
      int cyc, rdl, nd; logic st;
      do_frame(1'b0, 2'd0, 4'd0, 32'd0, 0, cyc, rdl, st, nd);
      checks++; if (cyc != 2) begin errors++; $display("FAIL idle_frame_done: got %0d want 2", cyc); end
      checks++; if (rdl != 0 || wr_log.size() != 0) begin errors++; $display("FAIL idle_no_cmd: reads=%0d writes=%0d want 0 0", rdl, wr_log.size()); end
      checks++; if (address !== 25'd0 || {play_data0, play_data1, play_data2, play_data3} !== 128'd0) begin errors++; $display("FAIL idle_outputs: addr=%h want 0", address); end
   endtask

   task automatic test_record();
      int cyc, rdl, nd; logic st;
      logic [31:0] dv [3];
      dv[0] = A; dv[1] = B; dv[2] = C;
      for (int t = 0; t < 3; t++) begin
         do_frame(1'b1, 2'd2, 4'd0, dv[t], 0, cyc, rdl, st, nd);
         checks++; if (cyc != 3) begin errors++; $display("FAIL rec_cycles[%0d]: got %0d want 3", t, cyc); end
         checks++; if (play_data2 !== dv[t]) begin errors++; $display("FAIL rec_monitor[%0d]: got %h want %h", t, play_data2, dv[t]); end
      end
      checks++; if (len2 !== 23'd3) begin errors++; $display("FAIL rec_len2: got %0d want 3", len2); end
      checks++;
      if (wr_log.size() != 3) begin errors++; $display("FAIL rec_wr_count: got %0d want 3", wr_log.size()); end
      else if (wr_log[0] !== 25'h1000000 || wr_log[1] !== 25'h1000001 || wr_log[2] !== 25'h1000002) begin
         errors++; $display("FAIL rec_wr_addr: got %h %h %h want 1000000 1000001 1000002", wr_log[0], wr_log[1], wr_log[2]);
      end
   endtask

   task automatic test_playback();
      int cyc, rdl, nd; logic st;
      logic [31:0] dv [4];
      logic [24:0] av [4];
      dv[0] = A; dv[1] = B; dv[2] = C; dv[3] = A;
      av[0] = 25'h1000000; av[1] = 25'h1000001; av[2] = 25'h1000002; av[3] = 25'h1000000;
      rd_log.delete();
      for (int t = 0; t < 4; t++) begin
         do_frame(1'b0, 2'd2, 4'b0100, 32'h0, 0, cyc, rdl, st, nd);
         checks++; if (cyc != 4) begin errors++; $display("FAIL play_cycles[%0d]: got %0d want 4", t, cyc); end
         checks++; if (play_data2 !== dv[t]) begin errors++; $display("FAIL play_data[%0d]: got %h want %h", t, play_data2, dv[t]); end
         checks++; if (rd_log.size() != t + 1 || rd_log[t] !== av[t]) begin errors++; $display("FAIL play_addr[%0d]: count=%0d want addr %h", t, rd_log.size(), av[t]); end
      end
   endtask

   task automatic test_stall();
      int cyc, rdl, nd; logic st;
      rd_log.delete();
      stall_cnt = 5;
      do_frame(1'b0, 2'd2, 4'b0100, 32'h0, 0, cyc, rdl, st, nd);
      checks++; if (cyc != 9) begin errors++; $display("FAIL stall_cycles: got %0d want 9", cyc); end
      checks++; if (rdl != 6 || st !== 1'b1) begin errors++; $display("FAIL stall_hold: read_n low %0d cycles stable=%b want 6 1", rdl, st); end
      checks++; if (rd_log.size() != 1 || rd_log[0] !== 25'h1000001) begin errors++; $display("FAIL stall_accept: count=%0d want 1 at 1000001", rd_log.size()); end
      checks++; if (play_data2 !== B) begin errors++; $display("FAIL stall_data: got %h want %h", play_data2, B); end
   endtask

   task automatic test_record_play();
      int cyc, rdl, nd; logic st;
      wr_log.delete(); rd_log.delete();
      do_frame(1'b1, 2'd0, 4'b0101, D, 0, cyc, rdl, st, nd);
      checks++; if (cyc != 5) begin errors++; $display("FAIL rp_cycles: got %0d want 5", cyc); end
      checks++; if (wr_log.size() != 1 || wr_log[0] !== 25'h0000000) begin errors++; $display("FAIL rp_write: count=%0d want 1 at 0", wr_log.size()); end
      checks++; if (rd_log.size() != 1 || rd_log[0] !== 25'h1000002) begin errors++; $display("FAIL rp_read: count=%0d want 1 at 1000002", rd_log.size()); end
      checks++; if (play_data0 !== D || play_data2 !== C) begin errors++; $display("FAIL rp_data: got %h %h want %h %h", play_data0, play_data2, D, C); end
      checks++; if (len0 !== 23'd1) begin errors++; $display("FAIL rp_len0: got %0d want 1", len0); end
   endtask

   task automatic test_max_len();
      int cyc, rdl, nd; logic st;
      wr_log.delete();
      for (int t = 1; t <= 6; t++) begin
         do_frame(1'b1, 2'd1, 4'd0, 32'h100 + 32'(t), 0, cyc, rdl, st, nd);
         checks++; if (cyc != ((t <= 4) ? 3 : 2)) begin errors++; $display("FAIL max_cycles[%0d]: got %0d want %0d", t, cyc, (t <= 4) ? 3 : 2); end
         checks++; if (rec_full !== (t >= 5)) begin errors++; $display("FAIL max_rec_full[%0d]: got %b want %b", t, rec_full, (t >= 5)); end
      end
      checks++; if (len1 !== 23'd4) begin errors++; $display("FAIL max_len1: got %0d want 4", len1); end
      checks++; if (wr_log.size() != 4 || wr_log[3] !== 25'h0800003) begin errors++; $display("FAIL max_writes: count=%0d want 4 ending at 0800003", wr_log.size()); end
      checks++; if (play_data1 !== 32'h106) begin errors++; $display("FAIL max_monitor: got %h want 00000106", play_data1); end
   endtask

   task automatic test_overrun();
      int cyc, rdl, nd; logic st;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", overrun); end
      do_frame(1'b0, 2'd1, 4'b0100, 32'h0, 2, cyc, rdl, st, nd);
      checks++; if (cyc != 4 || nd != 1) begin errors++; $display("FAIL ovr_frame: cycles=%0d done_pulses=%0d want 4 1", cyc, nd); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
      checks++; if (rec_full !== 1'b0) begin errors++; $display("FAIL ovr_rec_full_clear: got %b want 0", rec_full); end
      checks++; if (play_data2 !== A) begin errors++; $display("FAIL ovr_data: got %h want %h", play_data2, A); end
      do_frame(1'b0, 2'd1, 4'd0, 32'h0, 0, cyc, rdl, st, nd);
      checks++; if (overrun !== 1'b1 || cyc != 2) begin errors++; $display("FAIL ovr_sticky: overrun=%b cycles=%0d want 1 2", overrun, cyc); end
   endtask

   task automatic test_reset_mid();
      int nd;
      stall_cnt = 20;
      record_en = 1'b0; play_mask = 4'b0100; sample_tick = 1'b1;
      @(negedge clk); sample_tick = 1'b0;
      @(negedge clk);
      checks++; if (read_n !== 1'b0) begin errors++; $display("FAIL mid_read_active: read_n=%b want 0", read_n); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; stall_cnt = 0;
      checks++; if (read_n !== 1'b1 || write_n !== 1'b1 || address !== 25'd0) begin errors++; $display("FAIL mid_cmd: read_n=%b write_n=%b addr=%h want 1 1 0", read_n, write_n, address); end
      checks++; if (len2 !== 23'd0 || play_data2 !== 32'd0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_state: len2=%0d play2=%h ovr=%b want 0", len2, play_data2, overrun); end
      nd = 0;
      repeat (5) begin @(negedge clk); if (frame_done === 1'b1 || read_n !== 1'b1) nd++; end
      checks++; if (nd != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles want 0", nd); end
   endtask

   initial begin
      test_reset();
      test_idle_tick();
      test_record();
      test_playback();
      test_stall();
      test_record_play();
      test_max_len();
      test_overrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
